arith_seq_ctrl: RTL and testbench

Multi-word sequencer for the 16-bit `arithmeticUnit`. It accepts one command (operation select, word count, initial carry) and streams operand word pairs into the unit, least-significant word first. It chains the unit's carry between words and streams each 16-bit result out. On completion it reports the final carry and a whole-operand equality flag. It sits between the instruction/control path and one `arithmeticUnit` instance, which it drives exclusively.

---
 rtl/arith_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_arith_seq_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/arith_seq_ctrl.sv
// Multi-word sequencer for the 16-bit arithmeticUnit: chains carry word by word.
// Optional zero accumulator: define ARITH_SEQ_ZERO_FLAG_EN to build stat_zero.
module arith_seq_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_sel,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_carry_in,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic             res_last,
  output logic             done,
  output logic             stat_carry,
  output logic             stat_equal,
  output logic             stat_zero,
  output logic [3:0]       au_sel,
  output logic             au_carry_in,
  output logic [15:0]      au_in_a,
  output logic [15:0]      au_in_b,
  input  logic [15:0]      au_out,
  input  logic             au_carry_out,
  input  logic             au_compare
);

  typedef enum logic [2:0] {
    IDLE, FETCH, EXEC, OUT, DONE
  } state_t;

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE   = LEN_W'(1);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, cnt_q, len_clamp;
  logic             carry_q, eq_q;
  logic             cmd_fire;

  assign cmd_fire  = (state_q == IDLE) && cmd_valid;
  assign len_clamp = (cmd_len > MAX_L) ? MAX_L : cmd_len;

  assign cmd_ready   = (state_q == IDLE);
  assign op_ready    = (state_q == FETCH);
  assign res_valid   = (state_q == OUT);
  assign done        = (state_q == DONE);
  assign au_carry_in = carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (cmd_valid)
               state_d = (cmd_len == '0) ? DONE : FETCH;
      FETCH: if (op_valid) state_d = EXEC;
      EXEC:  state_d = OUT;
      OUT:   if (res_ready)
               state_d = res_last ? DONE : FETCH;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      au_sel     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      eq_q       <= 1'b0;
      au_in_a    <= '0;
      au_in_b    <= '0;
      res_data   <= '0;
      res_last   <= 1'b0;
      stat_carry <= 1'b0;
      stat_equal <= 1'b0;
    end else begin
      if (cmd_fire) begin
        au_sel  <= cmd_sel;
        len_q   <= len_clamp;
        carry_q <= cmd_carry_in;
        cnt_q   <= '0;
        eq_q    <= 1'b1;
      end
      if (state_q == FETCH && op_valid) begin
        au_in_a <= op_a;
        au_in_b <= op_b;
      end
      // unit outputs have settled by the end of EXEC
      if (state_q == EXEC) begin
        res_data <= au_out;
        carry_q  <= au_carry_out;
        eq_q     <= eq_q & au_compare;
        res_last <= (cnt_q == len_q - ONE);
      end
      if (state_q == OUT && res_ready && !res_last)
        cnt_q <= cnt_q + ONE;
      if (state_q == DONE) begin
        stat_carry <= carry_q;
        stat_equal <= eq_q;
      end
    end
  end

`ifdef ARITH_SEQ_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q    <= 1'b0;
      stat_zero <= 1'b0;
    end else begin
      if (cmd_fire)
        zero_q <= 1'b1;
      else if (state_q == EXEC)
        zero_q <= zero_q & (au_out == 16'h0000);
      if (state_q == DONE)
        stat_zero <= zero_q;
    end
  end
`else
  assign stat_zero = 1'b0;
`endif

endmodule

// File: tb/tb_arith_seq_ctrl.sv
// Bench for arith_seq_ctrl with a behavioural arithmeticUnit and a result scoreboard.
// Expected results are queued at operand handshake and checked at result handshake.
module tb_arith_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_sel;
  logic [3:0]  cmd_len;
  logic        cmd_carry_in;
  logic        op_valid, op_ready;
  logic [15:0] op_a, op_b;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic        res_last, done;
  logic        stat_carry, stat_equal, stat_zero;
  logic [3:0]  au_sel;
  logic        au_carry_in;
  logic [15:0] au_in_a, au_in_b, au_out;
  logic        au_carry_out, au_compare;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [15:0] wa[16];
  logic [15:0] wb[16];
  logic [16:0] sb[$];

  arith_seq_ctrl #(.MAX_LEN(8), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_len(cmd_len),
    .cmd_carry_in(cmd_carry_in),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_last(res_last),
    .done(done),
    .stat_carry(stat_carry), .stat_equal(stat_equal),
    .stat_zero(stat_zero),
    .au_sel(au_sel), .au_carry_in(au_carry_in),
    .au_in_a(au_in_a), .au_in_b(au_in_b),
    .au_out(au_out), .au_carry_out(au_carry_out),
    .au_compare(au_compare)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Unit model: 0000 = bitwise AND (carry 0), otherwise add with carry.
  function automatic logic [16:0] unit_fn(
    input logic [3:0] s, input logic [15:0] a,
    input logic [15:0] b, input logic ci);
    if (s == 4'b0000) return {1'b0, a & b};
    return {1'b0, a} + {1'b0, b} + {16'h0, ci};
  endfunction

  logic [16:0] au_res;
  always_comb begin
    au_res       = unit_fn(au_sel, au_in_a, au_in_b, au_carry_in);
    au_out       = au_res[15:0];
    au_carry_out = au_res[16];
    au_compare   = (au_in_a == au_in_b);
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rst_vec();
    return {3'b0, cmd_ready, op_ready, res_valid, res_last, done,
            res_data, au_sel, au_carry_in, au_in_a, au_in_b,
            stat_carry, stat_equal, stat_zero};
  endfunction

  localparam logic [63:0] RST_EXP = {3'b0, 1'b1, 60'h0};

  // Runs one command; abort_w >= 0 resets the DUT during OUT of that word.
  task automatic run_cmd(input string tag, input logic [3:0] sel,
                         input logic [3:0] len, input logic cin,
                         input int stall, input int abort_w);
    int n, k, hs;
    logic [16:0] r, e;
    logic c, eq, zr, zexp, bad;
    logic [15:0] held;
    n = (len > 4'd8) ? 8 : int'(len);
    c = cin; eq = 1'b1; zr = 1'b1; bad = 1'b0;
    cmd_sel = sel; cmd_len = len; cmd_carry_in = cin;
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
    chk({tag, " cmd_ready"}, 64'(cmd_ready), 64'd1);
    hs = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int w = 0; w < n; w++) begin
      op_a = wa[w]; op_b = wb[w]; op_valid = 1'b1;
      k = 0;
      while (!op_ready && k < 20) begin @(negedge clk); k++; end
      chk({tag, " op_ready"}, 64'(op_ready), 64'd1);
      r = unit_fn(sel, wa[w], wb[w], c);
      sb.push_back({w == n - 1, r[15:0]});
      c  = r[16];
      eq = eq & (wa[w] == wb[w]);
      zr = zr & (r[15:0] == 16'h0);
      @(negedge clk);
      op_valid = 1'b0;
      res_ready = (stall == 0);
      k = 0;
      while (!res_valid && k < 20) begin @(negedge clk); k++; end
      chk({tag, " res_valid"}, 64'(res_valid), 64'd1);
      if (w == abort_w) begin
        res_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk({tag, " reset values"}, rst_vec(), RST_EXP);
        @(negedge clk);
        chk({tag, " held in reset"}, rst_vec(), RST_EXP);
        rst_n = 1'b1;
        sb.delete();
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk({tag, " no done after reset"},
              {done, cmd_ready, op_ready}, 3'b010);
        end
        return;
      end
      held = res_data;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk({tag, " stall hold"}, {res_valid, op_ready, res_data},
            {1'b1, 1'b0, held});
      end
      res_ready = 1'b1;
      e = sb.pop_front();
      chk({tag, " result"}, {res_last, res_data}, e);
      @(negedge clk);
      res_ready = 1'b0;
    end
    k = 0;
    while (!done && k < 20) begin
      bad = bad | op_ready | res_valid;
      @(negedge clk);
      k++;
    end
    chk({tag, " no handshake before done"}, 64'(bad), 64'd0);
    chk({tag, " done latency"}, 64'(cyc - hs), 64'(3 * n + 1 + stall * n));
    @(negedge clk);
`ifdef ARITH_SEQ_ZERO_FLAG_EN
    zexp = zr;
`else
    zexp = 1'b0;
`endif
    chk({tag, " status"},
        {stat_carry, stat_equal, stat_zero, done, cmd_ready},
        {c, eq, zexp, 1'b0, 1'b1});
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_sel = '0; cmd_len = '0;
    cmd_carry_in = 1'b0;
    op_valid = 1'b0; op_a = '0; op_b = '0;
    res_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("power-on reset", rst_vec(), RST_EXP);
    rst_n = 1'b1;
    @(negedge clk);

    wa[0] = 16'hFFFF; wa[1] = 16'hFFFF; wa[2] = 16'h0000;
    wb[0] = 16'h0001; wb[1] = 16'h0000; wb[2] = 16'h0000;
    run_cmd("add3", 4'b1001, 4'd3, 1'b0, 0, -1);

    wa[0] = 16'h1234; wa[1] = 16'hABCD;
    wb[0] = 16'h1234; wb[1] = 16'hABCD;
    run_cmd("eq2", 4'b0000, 4'd2, 1'b0, 0, -1);
    wb[1] = 16'hABCE;
    run_cmd("neq2", 4'b0000, 4'd2, 1'b0, 0, -1);

    run_cmd("len0", 4'b1001, 4'd0, 1'b1, 0, -1);

    for (int i = 0; i < 4; i++) begin
      wa[i] = 16'(16'h1111 * (i + 1));
      wb[i] = 16'(16'h0101 * (i + 3));
    end
    run_cmd("abort", 4'b1001, 4'd4, 1'b0, 0, 1);

    wa[0] = 16'hFFFF; wa[1] = 16'hFFFF; wa[2] = 16'h0000;
    wb[0] = 16'h0001; wb[1] = 16'h0000; wb[2] = 16'h0000;
    run_cmd("add3 after reset", 4'b1001, 4'd3, 1'b0, 0, -1);

    wa[0] = 16'h8001; wb[0] = 16'h8002;
    run_cmd("backpressure", 4'b1001, 4'd1, 1'b1, 5, -1);

    for (int i = 0; i < 16; i++) begin
      wa[i] = 16'($urandom);
      wb[i] = 16'($urandom);
    end
    run_cmd("clamp", 4'b1001, 4'd15, 1'b1, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
